// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared widths, window field offsets and FSM encoding for window_3x3_gen
//
// Purpose: constants shared by window_3x3_gen and line_buffer.
//   PIX_W / WIN_W        : pixel width (RGB444) and packed 3x3 window width
//   OFF_*                : bit offset of each neighbour slot inside color_data
//   ST_*                 : FSM state encoding
package window_pkg;

  localparam int PIX_W = 12;
  localparam int WIN_W = 9 * PIX_W;

  localparam int OFF_CENTRE    = 96;
  localparam int OFF_LEFT      = 84;
  localparam int OFF_RIGHT     = 72;
  localparam int OFF_UP        = 60;
  localparam int OFF_DOWN      = 48;
  localparam int OFF_UPLEFT    = 36;
  localparam int OFF_UPRIGHT   = 24;
  localparam int OFF_DOWNLEFT  = 12;
  localparam int OFF_DOWNRIGHT = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-line read-before-write pixel delay line
//
// Purpose: delays a pixel stream by exactly DEPTH enabled cycles.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset (read/write pointer only)
//   en    : advance the line by one pixel
//   din   : pixel written into the line
//   dout  : pixel written DEPTH enables ago (valid before the write)
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = 160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Same slot is read and then overwritten, so dout is the oldest pixel.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - raster-order 3x3 neighbourhood window generator
//
// Purpose: turns a raster RGB444 pixel stream into one 3x3 window per pixel,
// in raster order of the centre pixel.
// Build option: WINDOW_BORDER_REPLICATE_EN - when defined, out-of-image
// neighbours replicate the nearest in-image pixel; otherwise they are zero.
// Ports:
//   clk          : clock
//   reset        : asynchronous active-high reset
//   sof          : start of frame, marks pixel (0,0) when pixel_valid
//   pixel_in     : RGB444 pixel
//   pixel_valid  : pixel_in valid, taken when in_ready is high
//   in_ready     : block accepts a pixel this cycle (low only while flushing)
//   color_data   : packed window {centre,left,right,up,down,ul,ur,dl,dr}
//   window_valid : one-cycle pulse per window
//   window_sof   : window is centred on (0,0)
module window_3x3_gen
  import window_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_valid,
  output logic             in_ready,
  output logic [WIN_W-1:0] color_data,
  output logic             window_valid,
  output logic             window_sof
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);

  logic [1:0]    state;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [CW-1:0] c_col;
  logic [RW-1:0] c_row;
  logic [CW-1:0] flush_cnt;

  logic accept, shift, emit, in_last;
  logic top_edge, bot_edge, lft_edge, rgt_edge;
  logic row_out, col_out;

  logic [PIX_W-1:0] lb_din, lb1_out, lb2_out;
  // Two previous window columns: a = line above centre, b = centre line, c = line below.
  logic [PIX_W-1:0] a1, a2, b1, b2, c1, c2;
  logic [PIX_W-1:0] nb  [3][3];
  logic [PIX_W-1:0] win [3][3];
  logic [WIN_W-1:0] win_packed;

  assign in_ready = (state != ST_FLUSH);
  assign accept   = pixel_valid && in_ready;
  // While flushing, zeros are pushed through the pipeline; they only ever
  // land in bottom-row neighbours, which are out of image and get masked.
  assign lb_din   = (state == ST_FLUSH) ? '0 : pixel_in;
  assign shift    = (accept && (sof || state != ST_IDLE)) || (state == ST_FLUSH);
  assign emit     = (state == ST_RUN && accept && !sof) || (state == ST_FLUSH);
  assign in_last  = (in_col == CW'(IMG_W - 1)) && (in_row == RW'(IMG_H - 1));

  assign top_edge = (c_row == '0);
  assign bot_edge = (c_row == RW'(IMG_H - 1));
  assign lft_edge = (c_col == '0);
  assign rgt_edge = (c_col == CW'(IMG_W - 1));

  line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .rst  (reset),
    .en   (shift),
    .din  (lb_din),
    .dout (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb2 (
    .clk  (clk),
    .rst  (reset),
    .en   (shift),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_ff @(posedge clk) begin
    if (shift) begin
      a2 <= a1;  a1 <= lb2_out;
      b2 <= b1;  b1 <= lb1_out;
      c2 <= c1;  c1 <= lb_din;
    end
  end

  // nb[row][col]: row 0 = up, 2 = down; col 0 = left, 2 = right.
  // The incoming column (line buffers + new pixel) is the right-hand column.
  always_comb begin
    nb[0][0] = a2;  nb[0][1] = a1;  nb[0][2] = lb2_out;
    nb[1][0] = b2;  nb[1][1] = b1;  nb[1][2] = lb1_out;
    nb[2][0] = c2;  nb[2][1] = c1;  nb[2][2] = lb_din;
  end

  always_comb begin
    row_out = 1'b0;
    col_out = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        row_out = (r == 0 && top_edge) || (r == 2 && bot_edge);
        col_out = (c == 0 && lft_edge) || (c == 2 && rgt_edge);
`ifdef WINDOW_BORDER_REPLICATE_EN
        // Nearest in-image pixel: pull the offending axis back to the centre.
        win[r][c] = nb[row_out ? 1 : r][col_out ? 1 : c];
`else
        win[r][c] = (row_out || col_out) ? '0 : nb[r][c];
`endif
      end
    end
  end

  always_comb begin
    win_packed = '0;
    win_packed[OFF_CENTRE    +: PIX_W] = win[1][1];
    win_packed[OFF_LEFT      +: PIX_W] = win[1][0];
    win_packed[OFF_RIGHT     +: PIX_W] = win[1][2];
    win_packed[OFF_UP        +: PIX_W] = win[0][1];
    win_packed[OFF_DOWN      +: PIX_W] = win[2][1];
    win_packed[OFF_UPLEFT    +: PIX_W] = win[0][0];
    win_packed[OFF_UPRIGHT   +: PIX_W] = win[0][2];
    win_packed[OFF_DOWNLEFT  +: PIX_W] = win[2][0];
    win_packed[OFF_DOWNRIGHT +: PIX_W] = win[2][2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_col    <= '0;
      in_row    <= '0;
      c_col     <= '0;
      c_row     <= '0;
      flush_cnt <= '0;
    end else begin
      if (emit) begin
        if (rgt_edge) begin
          c_col <= '0;
          c_row <= bot_edge ? '0 : c_row + RW'(1);
        end else begin
          c_col <= c_col + CW'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (accept && sof) begin
            state  <= ST_FILL;
            in_col <= CW'(1);
            in_row <= '0;
            c_col  <= '0;
            c_row  <= '0;
          end
        end
        ST_FILL, ST_RUN: begin
          if (accept) begin
            if (sof) begin
              // Restart: the sof pixel becomes (0,0) of the new frame.
              state  <= ST_FILL;
              in_col <= CW'(1);
              in_row <= '0;
              c_col  <= '0;
              c_row  <= '0;
            end else begin
              if (in_col == CW'(IMG_W - 1)) begin
                in_col <= '0;
                in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + RW'(1);
              end else begin
                in_col <= in_col + CW'(1);
              end
              // Pixel (1,0) is the (IMG_W+1)th held pixel.
              if (state == ST_FILL && in_row == RW'(1) && in_col == '0) begin
                state <= ST_RUN;
              end
              if (state == ST_RUN && in_last) begin
                state     <= ST_FLUSH;
                flush_cnt <= '0;
              end
            end
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + CW'(1);
          if (flush_cnt == CW'(IMG_W)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_data   <= '0;
      window_valid <= 1'b0;
      window_sof   <= 1'b0;
    end else begin
      window_valid <= emit;
      window_sof   <= emit && top_edge && lft_edge;
      if (emit) begin
        color_data <= win_packed;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - self-checking bench for window_3x3_gen (IMG_W=4, IMG_H=3)
`timescale 1ns/1ps
module tb_window_3x3_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         reset;
  logic         sof;
  logic [11:0]  pixel_in;
  logic         pixel_valid;
  logic         in_ready;
  logic [107:0] color_data;
  logic         window_valid;
  logic         window_sof;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .sof          (sof),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .in_ready     (in_ready),
    .color_data   (color_data),
    .window_valid (window_valid),
    .window_sof   (window_sof)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic [11:0] p;
    logic        rdy;
    logic        wv;
  } vec_t;

  vec_t         tbl [21];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [108:0] sb [$];
  logic [11:0]  fr [N];
  int           m_idx   = -1;
  int           m_flush = 0;
  int           win_count = 0;
  int           sof_count = 0;
  logic [107:0] first_win, last_win, first_exp, last_exp;
  logic         rdy_o, wv_o;
  int           base;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [107:0] exp_win(input int c);
    logic [11:0] v [3][3];
    int r, col, rr, cc;
    r   = c / W;
    col = c % W;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = col + dc - 1;
`ifdef WINDOW_BORDER_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr >= H) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc >= W) cc = W - 1;
        v[dr][dc] = fr[rr * W + cc];
`else
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) v[dr][dc] = 12'h000;
        else v[dr][dc] = fr[rr * W + cc];
`endif
      end
    end
    return {v[1][1], v[1][0], v[1][2], v[0][1], v[2][1], v[0][0], v[0][2], v[2][0], v[2][2]};
  endfunction

  // One clock: drive inputs, let the reference model predict, then compare after the edge.
  task automatic step(input logic v, input logic s, input logic [11:0] p,
                      output logic rdy_obs, output logic wv_obs);
    logic         exp_rdy, exp_wv;
    logic [108:0] e;
    pixel_valid = v;
    sof         = s;
    pixel_in    = p;
    exp_rdy     = (m_flush == 0);
    exp_wv      = 1'b0;
    rdy_obs     = in_ready;
    check("in_ready", in_ready, exp_rdy);
    if (!exp_rdy) begin
      sb.push_back({1'b0, exp_win(N - m_flush)});
      exp_wv = 1'b1;
      m_flush--;
    end else if (v) begin
      if (s) begin
        fr[0] = p;
        m_idx = 1;
      end else if (m_idx >= 0) begin
        fr[m_idx] = p;
        if (m_idx >= W + 1) begin
          sb.push_back({(m_idx == W + 1), exp_win(m_idx - W - 1)});
          exp_wv = 1'b1;
        end
        m_idx++;
        if (m_idx == N) begin
          m_idx   = -1;
          m_flush = W + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    wv_obs = window_valid;
    check("window_valid", window_valid, exp_wv);
    if (window_valid) begin
      win_count++;
      last_win = color_data;
      if (window_sof) begin
        sof_count++;
        first_win = color_data;
      end
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (window_valid) check("window", {window_sof, color_data}, e);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, rdy_o, wv_o);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)   tbl[i] = '{1'b1, (i == 0), 12'(i), 1'b1, (i >= 5)};
    for (int i = 8; i < 11; i++)  tbl[i] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
    for (int i = 11; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 12'(i - 3), 1'b1, 1'b1};
    for (int i = 15; i < 20; i++) tbl[i] = '{1'b1, 1'b0, 12'h0FF, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0};

`ifdef WINDOW_BORDER_REPLICATE_EN
    first_exp = {12'h000, 12'h000, 12'h001, 12'h000, 12'h004, 12'h000, 12'h001, 12'h004, 12'h005};
    last_exp  = {12'h00B, 12'h00A, 12'h00B, 12'h007, 12'h00B, 12'h006, 12'h007, 12'h00A, 12'h00B};
`else
    first_exp = {12'h000, 12'h000, 12'h001, 12'h000, 12'h004, 12'h000, 12'h000, 12'h000, 12'h005};
    last_exp  = {12'h00B, 12'h00A, 12'h000, 12'h007, 12'h000, 12'h006, 12'h000, 12'h000, 12'h000};
`endif

    reset = 1'b1; sof = 1'b0; pixel_valid = 1'b0; pixel_in = 12'h000;
    first_win = '0; last_win = '0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_window_valid", window_valid, 1'b0);
    check("reset_window_sof", window_sof, 1'b0);
    check("reset_color_data", color_data, 108'h0);
    reset = 1'b0;

    // Frame with a three-cycle gap after pixel 7, then flush with pixel_valid held.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].p, rdy_o, wv_o);
      check($sformatf("tbl_rdy[%0d]", i), rdy_o, tbl[i].rdy);
      check($sformatf("tbl_wv[%0d]", i), wv_o, tbl[i].wv);
    end
    check("gap_frame_windows", win_count, 12);
    check("gap_frame_first", first_win, first_exp);
    check("gap_frame_last", last_win, last_exp);

    // Continuous frame.
    win_count = 0; sof_count = 0; first_win = '0;
    for (int i = 0; i < N; i++) step(1'b1, (i == 0), 12'(i), rdy_o, wv_o);
    idle_steps(W + 2);
    check("cont_frame_windows", win_count, 12);
    check("cont_frame_sofs", sof_count, 1);
    check("cont_frame_first", first_win, first_exp);
    check("cont_frame_last", last_win, last_exp);

    // Abort: new sof after 8 accepted pixels.
    win_count = 0; sof_count = 0;
    for (int i = 0; i < 8; i++) step(1'b1, (i == 0), 12'(i), rdy_o, wv_o);
    check("abort_old_windows", win_count, 3);
    base = win_count;
    step(1'b1, 1'b1, 12'h100, rdy_o, wv_o);
    check("abort_sof_no_window", wv_o, 1'b0);
    for (int i = 1; i < N; i++) step(1'b1, 1'b0, 12'h100 + 12'(i), rdy_o, wv_o);
    idle_steps(W + 2);
    check("abort_new_windows", win_count - base, 12);
    check("abort_sofs", sof_count, 2);

    // Reset in the middle of RUN.
    for (int i = 0; i < 7; i++) step(1'b1, (i == 0), 12'(i), rdy_o, wv_o);
    check("pre_reset_window", wv_o, 1'b1);
    pixel_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_window_valid", window_valid, 1'b0);
    check("midrst_color_data", color_data, 108'h0);
    check("midrst_in_ready", in_ready, 1'b1);
    m_idx = -1; m_flush = 0; sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    base = win_count;
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 12'(i), rdy_o, wv_o);
    check("post_reset_no_windows", win_count - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
